// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver:
// FSM state encoding, hex-to-segment table (active-high, {g,f,e,d,c,b,a}) and blank pattern.
package seg7_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [6:0] HEX_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder; produces the active-high pattern,
// output polarity is applied by the parent.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: synchronises scan_clk, steps one digit per rising edge
// and snapshots the display data once per frame. Optional macro: SEG7_BLANK_LEADING_ZERO_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    scan_clk,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int                    IW       = $clog2(NUM_DIGITS);
   localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{SEG_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

   logic [1:0]              rst_sync_reg;
   logic                    rst_int_n;
   logic [2:0]              sync_reg;
   logic                    tick;
   state_t                  state_reg, state_next;
   logic [IW-1:0]           idx_reg, idx_next;
   logic [4*NUM_DIGITS-1:0] snap_data_reg, snap_data_next;
   logic [NUM_DIGITS-1:0]   snap_dp_reg, snap_dp_next;
   logic                    frame_done_next;
   logic [NUM_DIGITS-1:0]   an_onehot;
   logic [3:0]              nibble_sel;
   logic                    dp_sel;
   logic                    lead_zero;
   logic [6:0]              pattern;
   logic [NUM_DIGITS-1:0]   an_reg;
   logic [6:0]              seg_reg;
   logic                    dp_reg;
   logic                    frame_done_reg;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_reg <= 2'b00;
      else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_int_n = rst_sync_reg[1];

   assign tick = sync_reg[1] & ~sync_reg[2];

   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      snap_data_next  = snap_data_reg;
      snap_dp_next    = snap_dp_reg;
      frame_done_next = 1'b0;
      if (!en) begin
         state_next = IDLE;
      end else if (tick) begin
         if (state_reg == IDLE || idx_reg == LAST_IDX) begin
            state_next      = SCAN;
            idx_next        = '0;
            snap_data_next  = data_in;
            snap_dp_next    = dp_in;
            frame_done_next = (state_reg == SCAN);
         end else begin
            idx_next = idx_reg + 1'b1;
         end
      end
   end

   // Outputs are derived from the next-state values so they register on the tick edge itself.
   always_comb begin
      nibble_sel = '0;
      dp_sel     = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_next == IW'(i)) begin
            nibble_sel = snap_data_next[4*i +: 4];
            dp_sel     = snap_dp_next[i];
         end
      end
   end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lead_zero  = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (snap_data_next[4*i +: 4] == 4'h0);
         if (idx_next == IW'(i)) lead_zero = upper_zero;
      end
   end
`else
   assign lead_zero = 1'b0;
`endif

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
         assign an_onehot[gi] = (idx_next == IW'(gi));
      end
   endgenerate

   seg7_hex_decode u_hex_decode (
      .nibble  (nibble_sel),
      .pattern (pattern)
   );

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync_reg       <= 3'b000;
         state_reg      <= IDLE;
         idx_reg        <= '0;
         snap_data_reg  <= '0;
         snap_dp_reg    <= '0;
         an_reg         <= AN_OFF;
         seg_reg        <= SEG_OFF;
         dp_reg         <= DP_OFF;
         frame_done_reg <= 1'b0;
      end else begin
         sync_reg       <= {sync_reg[1:0], scan_clk};
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         snap_data_reg  <= snap_data_next;
         snap_dp_reg    <= snap_dp_next;
         frame_done_reg <= frame_done_next;
         if (state_next == IDLE) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_OFF;
            dp_reg  <= DP_OFF;
         end else begin
            an_reg  <= an_onehot ^ AN_OFF;
            seg_reg <= (lead_zero ? SEG_BLANK : pattern) ^ SEG_OFF;
            dp_reg  <= dp_sel ^ DP_OFF;
         end
      end
   end

   assign an         = an_reg;
   assign seg        = seg_reg;
   assign dp         = dp_reg;
   assign frame_done = frame_done_reg;

endmodule
